// File: rtl/obuf_a_data_pkg.sv
// Shared constants and types for the router output-buffer slice.
package obuf_a_data_pkg;

    localparam int unsigned NPORT_DEF  = 5;
    localparam int unsigned PYLD_W_DEF = 17;

    // Input port indices as seen by the arbiter grant vector.
    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_S = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // Copy phase of the flit at the FIFO head.
    typedef enum logic {
        PH_FIRST = 1'b0,
        PH_COPY  = 1'b1
    } phase_e;

endpackage

// File: rtl/obuf_a_data_if.sv
// Link-side handshake bundle between an output buffer and the next hop.
interface obuf_a_data_if
    import obuf_a_data_pkg::*;
#(
    parameter int unsigned PYLD_W = PYLD_W_DEF
);
    logic              obuf_vld;
    logic              link_rdy;
    logic [PYLD_W-1:0] payload_o;
    logic              cpy_flag;

    modport master (output obuf_vld, output payload_o, output cpy_flag, input link_rdy);
    modport slave  (input obuf_vld, input payload_o, input cpy_flag, output link_rdy);
endinterface

// File: rtl/obuf_a_data_fifo.sv
// Small power-of-two FIFO with registered count and combinational head read.
module obuf_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Overflow/underflow guards keep count inside 0..DEPTH regardless of caller.
    assign do_push = push & (count != FULL_CNT);
    assign do_pop  = pop & (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage, pointers (wrap modulo DEPTH) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/obuf_a_data.sv
// Output-port data buffer: grant mux into a FIFO, link handshake with optional flit copy.
module obuf_a_data
    import obuf_a_data_pkg::*;
#(
    parameter int unsigned PYLD_W = PYLD_W_DEF,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned NPORT  = NPORT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        arb_gnt,
    input  logic [NPORT*PYLD_W-1:0] payload_i,
    output logic                    obuf_rdy,
    input  logic                    pg_en,
    input  logic                    cpy_mode,
    obuf_a_data_if.master           link,
    output logic                    gnt_err
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0]     count;
    logic [PYLD_W:0]   head;
    logic              head_cpy;
    logic [PYLD_W-1:0] sel_pyld;
    logic              multi_hot;
    logic              push;
    logic              pop;
    logic              beat;
    phase_e            phase;

    assign obuf_rdy = (count < FULL_CNT);
    assign push     = (|arb_gnt) & obuf_rdy;
    assign multi_hot = (arb_gnt & (arb_gnt - 1'b1)) != '0;

    // Lowest-index granted port wins the payload mux.
    always_comb begin
        sel_pyld = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (arb_gnt[i]) begin
                sel_pyld = payload_i[i*PYLD_W +: PYLD_W];
            end
        end
    end

    obuf_fifo #(
        .W     (PYLD_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({pg_en & cpy_mode, sel_pyld}),
        .dout  (head),
        .count (count)
    );

    assign head_cpy       = head[PYLD_W];
    assign link.obuf_vld  = (count != '0);
    assign link.payload_o = head[PYLD_W-1:0];
    assign link.cpy_flag  = head_cpy & (phase == PH_COPY);

    assign beat = link.obuf_vld & link.link_rdy;
    assign pop  = beat & (~head_cpy | (phase == PH_COPY));

    // Copy-phase tracking: a copy-tagged head needs two link beats before it pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_FIRST;
        end else if (beat && head_cpy) begin
            phase <= (phase == PH_FIRST) ? PH_COPY : PH_FIRST;
        end
    end

    // Flag a multi-hot grant that actually pushed; pulses for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_err <= 1'b0;
        end else begin
            gnt_err <= push & multi_hot;
        end
    end
endmodule

// File: tb/tb_obuf_a_data.sv
// Directed self-checking bench for obuf_a_data.
module tb_obuf_a_data;
    import obuf_a_data_pkg::*;

    localparam int unsigned PW = 17;
    localparam int unsigned NP = 5;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    arb_gnt;
    logic [NP*PW-1:0] payload_i;
    logic             obuf_rdy;
    logic             pg_en;
    logic             cpy_mode;
    logic             gnt_err;

    int checks;
    int failures;

    obuf_a_data_if #(.PYLD_W(PW)) link ();

    obuf_a_data #(
        .PYLD_W (PW),
        .DEPTH  (2),
        .NPORT  (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arb_gnt   (arb_gnt),
        .payload_i (payload_i),
        .obuf_rdy  (obuf_rdy),
        .pg_en     (pg_en),
        .cpy_mode  (cpy_mode),
        .link      (link.master),
        .gnt_err   (gnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int k, input logic [PW-1:0] v);
        payload_i[k*PW +: PW] = v;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", link.obuf_vld); end
        checks++; if (obuf_rdy !== 1'b1) begin failures++; $display("FAIL rst_rdy got=%b exp=1", obuf_rdy); end
        checks++; if (link.payload_o !== 17'h0) begin failures++; $display("FAIL rst_payload got=%h exp=0", link.payload_o); end
        checks++; if (link.cpy_flag !== 1'b0) begin failures++; $display("FAIL rst_cpy got=%b exp=0", link.cpy_flag); end
        checks++; if (gnt_err !== 1'b0) begin failures++; $display("FAIL rst_gnt_err got=%b exp=0", gnt_err); end
        tick();
        rst = 1'b0;
        // queue two flits with the link stalled, then reset mid-run
        link.link_rdy = 1'b0;
        arb_gnt = 5'b00001;
        set_pl(int'(PORT_N), 17'h11111);
        tick();
        set_pl(int'(PORT_N), 17'h02222);
        tick();
        arb_gnt = '0;
        checks++; if (link.obuf_vld !== 1'b1) begin failures++; $display("FAIL midrun_vld got=%b exp=1", link.obuf_vld); end
        checks++; if (obuf_rdy !== 1'b0) begin failures++; $display("FAIL midrun_full got=%b exp=0", obuf_rdy); end
        checks++; if (link.payload_o !== 17'h11111) begin failures++; $display("FAIL midrun_head got=%h exp=11111", link.payload_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL async_rst_vld got=%b exp=0", link.obuf_vld); end
        checks++; if (obuf_rdy !== 1'b1) begin failures++; $display("FAIL async_rst_rdy got=%b exp=1", obuf_rdy); end
        checks++; if (link.payload_o !== 17'h0) begin failures++; $display("FAIL async_rst_payload got=%h exp=0", link.payload_o); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL post_rst_vld got=%b exp=0", link.obuf_vld); end
    endtask

    task automatic test_single();
        link.link_rdy = 1'b1;
        arb_gnt = 5'b00100;
        set_pl(int'(PORT_S), 17'h1A5A5);
        tick();
        arb_gnt = '0;
        checks++; if (link.obuf_vld !== 1'b1) begin failures++; $display("FAIL single_vld got=%b exp=1", link.obuf_vld); end
        checks++; if (link.payload_o !== 17'h1A5A5) begin failures++; $display("FAIL single_payload got=%h exp=1a5a5", link.payload_o); end
        checks++; if (link.cpy_flag !== 1'b0) begin failures++; $display("FAIL single_cpy got=%b exp=0", link.cpy_flag); end
        checks++; if (gnt_err !== 1'b0) begin failures++; $display("FAIL single_gnt_err got=%b exp=0", gnt_err); end
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", link.obuf_vld); end
        checks++; if (obuf_rdy !== 1'b1) begin failures++; $display("FAIL single_rdy got=%b exp=1", obuf_rdy); end
    endtask

    task automatic test_stall();
        link.link_rdy = 1'b0;
        arb_gnt = 5'b00010;
        set_pl(int'(PORT_E), 17'h0AAA1);
        tick();
        checks++; if (obuf_rdy !== 1'b1) begin failures++; $display("FAIL stall_rdy1 got=%b exp=1", obuf_rdy); end
        set_pl(int'(PORT_E), 17'h0BBB2);
        tick();
        checks++; if (obuf_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy2 got=%b exp=0", obuf_rdy); end
        set_pl(int'(PORT_E), 17'h0CCC3);
        tick();
        checks++; if (obuf_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy3 got=%b exp=0", obuf_rdy); end
        checks++; if (link.payload_o !== 17'h0AAA1) begin failures++; $display("FAIL stall_hold1 got=%h exp=0aaa1", link.payload_o); end
        arb_gnt = '0;
        tick();
        checks++; if (link.obuf_vld !== 1'b1) begin failures++; $display("FAIL stall_vld got=%b exp=1", link.obuf_vld); end
        checks++; if (link.payload_o !== 17'h0AAA1) begin failures++; $display("FAIL stall_hold2 got=%h exp=0aaa1", link.payload_o); end
        link.link_rdy = 1'b1;
        tick();
        checks++; if (link.payload_o !== 17'h0BBB2) begin failures++; $display("FAIL stall_order got=%h exp=0bbb2", link.payload_o); end
        checks++; if (link.obuf_vld !== 1'b1) begin failures++; $display("FAIL stall_vld2 got=%b exp=1", link.obuf_vld); end
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL stall_drop3 got=%b exp=0", link.obuf_vld); end
    endtask

    task automatic test_copy();
        link.link_rdy = 1'b1;
        pg_en = 1'b1;
        cpy_mode = 1'b1;
        arb_gnt = 5'b01000;
        set_pl(int'(PORT_W), 17'h00F0F);
        tick();
        arb_gnt = '0;
        cpy_mode = 1'b0;
        checks++; if (link.payload_o !== 17'h00F0F) begin failures++; $display("FAIL copy_beat1_payload got=%h exp=00f0f", link.payload_o); end
        checks++; if (link.cpy_flag !== 1'b0) begin failures++; $display("FAIL copy_beat1_flag got=%b exp=0", link.cpy_flag); end
        tick();
        checks++; if (link.obuf_vld !== 1'b1) begin failures++; $display("FAIL copy_beat2_vld got=%b exp=1", link.obuf_vld); end
        checks++; if (link.payload_o !== 17'h00F0F) begin failures++; $display("FAIL copy_beat2_payload got=%h exp=00f0f", link.payload_o); end
        checks++; if (link.cpy_flag !== 1'b1) begin failures++; $display("FAIL copy_beat2_flag got=%b exp=1", link.cpy_flag); end
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL copy_empty got=%b exp=0", link.obuf_vld); end
        pg_en = 1'b0;
        cpy_mode = 1'b1;
        arb_gnt = 5'b10000;
        set_pl(int'(PORT_L), 17'h12345);
        tick();
        arb_gnt = '0;
        checks++; if (link.cpy_flag !== 1'b0) begin failures++; $display("FAIL nopg_flag got=%b exp=0", link.cpy_flag); end
        checks++; if (link.payload_o !== 17'h12345) begin failures++; $display("FAIL nopg_payload got=%h exp=12345", link.payload_o); end
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL nopg_single got=%b exp=0", link.obuf_vld); end
        cpy_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_head;
        // fill with link stalled
        link.link_rdy = 1'b0;
        arb_gnt = 5'b00001;
        set_pl(int'(PORT_N), 17'h0D000);
        tick();
        set_pl(int'(PORT_N), 17'h0D001);
        tick();
        checks++; if (obuf_rdy !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", obuf_rdy); end
        // full + pop: this grant (X0) must be ignored
        link.link_rdy = 1'b1;
        set_pl(int'(PORT_N), 17'h1E000);
        checks++; if (link.payload_o !== 17'h0D000) begin failures++; $display("FAIL b2b_head0 got=%h exp=0d000", link.payload_o); end
        tick();
        checks++; if (link.payload_o !== 17'h0D001) begin failures++; $display("FAIL b2b_head1 got=%h exp=0d001", link.payload_o); end
        checks++; if (obuf_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy got=%b exp=1", obuf_rdy); end
        for (int k = 1; k <= 6; k++) begin
            exp_head = 17'h1E000 + PW'(k);
            set_pl(int'(PORT_N), exp_head);
            tick();
            checks++; if (link.payload_o !== exp_head) begin failures++; $display("FAIL b2b_stream%0d got=%h exp=%h", k, link.payload_o, exp_head); end
            checks++; if (link.obuf_vld !== 1'b1 || obuf_rdy !== 1'b1) begin failures++; $display("FAIL b2b_flow%0d got vld=%b rdy=%b exp vld=1 rdy=1", k, link.obuf_vld, obuf_rdy); end
        end
        arb_gnt = '0;
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", link.obuf_vld); end
    endtask

    task automatic test_gnt_err();
        link.link_rdy = 1'b0;
        arb_gnt = 5'b10010;
        set_pl(int'(PORT_E), 17'h0AAAA);
        set_pl(int'(PORT_L), 17'h15555);
        tick();
        arb_gnt = '0;
        checks++; if (gnt_err !== 1'b1) begin failures++; $display("FAIL gnt_err_pulse got=%b exp=1", gnt_err); end
        checks++; if (link.payload_o !== 17'h0AAAA) begin failures++; $display("FAIL gnt_err_lowest got=%h exp=0aaaa", link.payload_o); end
        tick();
        checks++; if (gnt_err !== 1'b0) begin failures++; $display("FAIL gnt_err_clear got=%b exp=0", gnt_err); end
        link.link_rdy = 1'b1;
        tick();
        checks++; if (link.obuf_vld !== 1'b0) begin failures++; $display("FAIL gnt_err_single got=%b exp=0", link.obuf_vld); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        arb_gnt = '0;
        payload_i = '0;
        pg_en = 1'b0;
        cpy_mode = 1'b0;
        link.link_rdy = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_copy();
        test_back_to_back();
        test_gnt_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
